// File: rtl/brick_collider.sv
// brick_collider
//   Requester in front of the brick status store. Each ball position is mapped
//   to a brick cell of a COLS x ROWS grid. When the position is inside the field,
//   one check_status transaction is run against the store, and deletion is requested
//   if the brick is present. The result goes to the ball controller as a hit or miss
//   pulse, and the module keeps a count of the bricks that remain.
//
// Ports
//   clock, resetn        system clock, asynchronous active-low reset
//   ball_x[7:0]          ball pixel x
//   ball_y[6:0]          ball pixel y
//   ball_valid           one-cycle strobe for a new ball position
//   loading              store is initialising bricks (reload count, abort, clear error)
//   ld_status            store status register load strobe
//   brick_status         store read data, valid while ld_status = 1
//   done_sig             store transaction complete pulse
//   brick_address[5:0]   row*COLS+col, stable from REQ through REPORT
//   check_status         one-cycle request pulse to the store
//   delete_brick         combinational delete request on the first ld_status of a request
//   busy                 high in every state except IDLE
//   hit, miss            one-cycle result pulses, mutually exclusive
//   hit_col[3:0]         grid column of the last reported in-field position
//   hit_row[2:0]         grid row of the last reported in-field position
//   bricks_left[5:0]     bricks remaining
//   field_clear          bricks_left == 0
//   timeout_err          sticky: the store never answered a request
//   state_dbg[2:0]       current FSM state, for observation
//
// Store handshake: check_status is a single-cycle request and cannot be
// withdrawn. The store answers with one or more ld_status strobes. Only the first
// strobe carries the read data of interest. The transaction ends with one done_sig
// pulse. done_sig is ignored unless a request is outstanding (state WAIT).
// If done_sig and the timeout arrive in the same cycle, done_sig wins.
module brick_collider #(
  parameter int COLS         = 10,
  parameter int ROWS         = 6,
  parameter int FIELD_X0     = 0,
  parameter int FIELD_Y0     = 16,
  parameter int BRICK_W_LOG2 = 4,
  parameter int BRICK_H_LOG2 = 3,
  parameter int TIMEOUT      = 15
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ball_x,
  input  logic [6:0] ball_y,
  input  logic       ball_valid,
  input  logic       loading,
  input  logic       ld_status,
  input  logic       brick_status,
  input  logic       done_sig,
  output logic [5:0] brick_address,
  output logic       check_status,
  output logic       delete_brick,
  output logic       busy,
  output logic       hit,
  output logic       miss,
  output logic [3:0] hit_col,
  output logic [2:0] hit_row,
  output logic [5:0] bricks_left,
  output logic       field_clear,
  output logic       timeout_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAP    = 3'd1,
    S_REQ    = 3'd2,
    S_WAIT   = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam int         CW    = $clog2(TIMEOUT + 1);
  localparam logic [5:0] TOTAL = 6'(COLS * ROWS);

  state_t          state, state_next;
  logic [7:0]      pos_x, pend_x;
  logic [6:0]      pos_y, pend_y;
  logic            pend_valid;
  logic [3:0]      col_q;
  logic [2:0]      row_q;
  logic [5:0]      addr_q;
  logic [CW-1:0]   wait_cnt;
  logic            seen_ld, seen_status;
  logic            timeout_hit;

  // Field mapping. The top bit of each difference is the borrow, which means the
  // position lies above or left of the field.
  logic [8:0] dx;
  logic [7:0] dy;
  logic [7:0] col_raw;
  logic [6:0] row_raw;
  logic [5:0] map_addr;
  logic       in_field;

  assign dx       = {1'b0, pos_x} - 9'(FIELD_X0);
  assign dy       = {1'b0, pos_y} - 8'(FIELD_Y0);
  assign col_raw  = dx[7:0] >> BRICK_W_LOG2;
  assign row_raw  = dy[6:0] >> BRICK_H_LOG2;
  assign in_field = !dx[8] && !dy[7] && (32'(col_raw) < COLS) && (32'(row_raw) < ROWS);
  assign map_addr = 6'(32'(row_raw) * COLS + 32'(col_raw));

  assign timeout_hit   = (wait_cnt == CW'(TIMEOUT));
  assign brick_address = addr_q;
  assign field_clear   = (bricks_left == 6'd0);
  assign state_dbg     = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next   = state;
    check_status = 1'b0;
    delete_brick = 1'b0;
    hit          = 1'b0;
    miss         = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE:   if (ball_valid || pend_valid) state_next = S_MAP;
      S_MAP:    state_next = in_field ? S_REQ : S_REPORT;
      S_REQ: begin
        check_status = 1'b1;
        state_next   = S_WAIT;
      end
      S_WAIT: begin
        // Later ld_status strobes are the store reloading after a delete.
        delete_brick = ld_status && !seen_ld && brick_status;
        if (done_sig || timeout_hit) state_next = S_REPORT;
      end
      S_REPORT: begin
        hit        = seen_status;
        miss       = !seen_status;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
    if (loading) state_next = S_IDLE;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pos_x       <= '0;
      pos_y       <= '0;
      pend_x      <= '0;
      pend_y      <= '0;
      pend_valid  <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      wait_cnt    <= '0;
      seen_ld     <= 1'b0;
      seen_status <= 1'b0;
      hit_col     <= '0;
      hit_row     <= '0;
      bricks_left <= TOTAL;
      timeout_err <= 1'b0;
    end else if (loading) begin
      bricks_left <= TOTAL;
      timeout_err <= 1'b0;
      pend_valid  <= 1'b0;
    end else begin
      // One-deep pending slot. A newer strobe overwrites an older one.
      if (state != S_IDLE && ball_valid) begin
        pend_valid <= 1'b1;
        pend_x     <= ball_x;
        pend_y     <= ball_y;
      end
      case (state)
        S_IDLE: begin
          if (ball_valid) begin
            pos_x      <= ball_x;
            pos_y      <= ball_y;
            pend_valid <= 1'b0;
          end else if (pend_valid) begin
            pos_x      <= pend_x;
            pos_y      <= pend_y;
            pend_valid <= 1'b0;
          end
        end
        S_MAP: begin
          seen_status <= 1'b0;
          if (in_field) begin
            col_q  <= col_raw[3:0];
            row_q  <= row_raw[2:0];
            addr_q <= map_addr;
          end
        end
        S_REQ: begin
          wait_cnt <= '0;
          seen_ld  <= 1'b0;
        end
        S_WAIT: begin
          if (ld_status && !seen_ld) begin
            seen_ld     <= 1'b1;
            seen_status <= brick_status;
          end
          if (!done_sig) begin
            if (timeout_hit) begin
              timeout_err <= 1'b1;
              seen_status <= 1'b0;   // an unanswered request is reported as a miss
            end else begin
              wait_cnt <= wait_cnt + CW'(1);
            end
          end
        end
        S_REPORT: begin
          hit_col <= col_q;
          hit_row <= row_q;
          if (seen_status && bricks_left != 6'd0) bricks_left <= bricks_left - 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_collider.sv
// tb_brick_collider
//   Drives ball positions into brick_collider, models the brick status store, and
//   compares results against a grid model computed from pixel arithmetic.
module tb_brick_collider;

  localparam int COLS = 10, ROWS = 6, FIELD_X0 = 0, FIELD_Y0 = 16;
  localparam int BRICK_W = 16, BRICK_H = 8, TIMEOUT = 15;
  localparam int NCELL = COLS * ROWS;

  logic       clock = 1'b0, resetn = 1'b0;
  logic [7:0] ball_x = '0;
  logic [6:0] ball_y = '0;
  logic       ball_valid = 1'b0, loading = 1'b0;
  logic       ld_status = 1'b0, brick_status = 1'b0, done_sig = 1'b0;
  logic [5:0] brick_address, bricks_left;
  logic       check_status, delete_brick, busy, hit, miss, field_clear, timeout_err;
  logic [3:0] hit_col;
  logic [2:0] hit_row;
  logic [2:0] state_dbg;

  brick_collider dut (
    .clock(clock), .resetn(resetn), .ball_x(ball_x), .ball_y(ball_y),
    .ball_valid(ball_valid), .loading(loading), .ld_status(ld_status),
    .brick_status(brick_status), .done_sig(done_sig), .brick_address(brick_address),
    .check_status(check_status), .delete_brick(delete_brick), .busy(busy),
    .hit(hit), .miss(miss), .hit_col(hit_col), .hit_row(hit_row),
    .bricks_left(bricks_left), .field_clear(field_clear), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // event logs filled by the monitor
  typedef struct { int cyc; logic [5:0] addr; logic is_hit; } ev_t;
  ev_t req_log[$], del_log[$], res_log[$];

  always @(negedge clock) begin
    #1;
    if (check_status) req_log.push_back('{cyc, brick_address, 1'b0});
    if (delete_brick) del_log.push_back('{cyc, brick_address, 1'b1});
    if (hit || miss) begin
      chk("hit_miss_exclusive", 32'(hit & miss), 32'd0);
      res_log.push_back('{cyc, brick_address, hit});
    end
  end

  // store model: ld at +2 after the request, done at +4; after a delete, a reload strobe and done two cycles later
  bit store_bricks[NCELL];
  bit store_mute = 1'b0;
  int store_a;
  bit store_d;
  always begin
    @(negedge clock);
    if (check_status && !store_mute) begin
      store_a = int'(brick_address);
      @(negedge clock);
      @(negedge clock);
      ld_status = 1'b1;
      brick_status = (store_a < NCELL) ? store_bricks[store_a] : 1'b0;
      #1 store_d = delete_brick;
      @(negedge clock);
      ld_status = 1'b0;
      brick_status = 1'b0;
      if (store_d && store_a < NCELL) store_bricks[store_a] = 1'b0;
      if (store_d) begin
        @(negedge clock);
        @(negedge clock);
        ld_status = 1'b1;
        @(negedge clock);
        ld_status = 1'b0;
        done_sig = 1'b1;
      end else begin
        @(negedge clock);
        done_sig = 1'b1;
      end
      @(negedge clock);
      done_sig = 1'b0;
    end
  end

  // reference model
  bit ref_bricks[NCELL];
  int ref_count = NCELL;

  function automatic void predict(input int x, input int y, output bit inf,
                                  output int a, output int col, output int row);
    inf = (x >= FIELD_X0) && (y >= FIELD_Y0);
    col = (x - FIELD_X0) / BRICK_W;
    row = (y - FIELD_Y0) / BRICK_H;
    if (inf) inf = (col < COLS) && (row < ROWS);
    a = row * COLS + col;
  endfunction

  task automatic wait_res(input int n, input int budget);
    int k = 0;
    while (res_log.size() < n && k < budget) begin
      @(negedge clock);
      #2;
      k++;
    end
    chk("result_arrived", 32'(res_log.size() >= n), 32'd1);
  endtask

  task automatic do_loading();
    @(negedge clock);
    loading = 1'b1;
    for (int i = 0; i < NCELL; i++) begin
      store_bricks[i] = 1'b1;
      ref_bricks[i] = 1'b1;
    end
    ref_count = NCELL;
    @(negedge clock);
    loading = 1'b0;
    #2;
    chk("load_bricks_left", 32'(bricks_left), 32'(NCELL));
    chk("load_field_clear", 32'(field_clear), 32'd0);
    chk("load_busy", 32'(busy), 32'd0);
    chk("load_timeout_err", 32'(timeout_err), 32'd0);
    chk("load_pulses", 32'({hit, miss, check_status, delete_brick}), 32'd0);
  endtask

  task automatic process(input int x, input int y);
    bit inf, pres, exp_hit;
    int a, col, row, t0, rel;
    ev_t r;
    predict(x, y, inf, a, col, row);
    pres = inf && ref_bricks[a];
    exp_hit = pres && !store_mute;
    req_log.delete(); del_log.delete(); res_log.delete();
    @(negedge clock);
    ball_x = 8'(x); ball_y = 7'(y); ball_valid = 1'b1; t0 = cyc;
    @(negedge clock);
    ball_valid = 1'b0;
    wait_res(1, 60);
    if (res_log.size() > 0) begin
      r = res_log.pop_front();
      rel = r.cyc - t0;
      chk("result_hit", 32'(r.is_hit), 32'(exp_hit));
      if (!inf) begin
        chk("oof_miss_cycle", 32'(rel), 32'd2);
        chk("oof_no_request", 32'(req_log.size()), 32'd0);
      end else begin
        chk("req_count", 32'(req_log.size()), 32'd1);
        if (req_log.size() > 0) begin
          chk("req_cycle", 32'(req_log[0].cyc - t0), 32'd2);
          chk("req_addr", 32'(req_log[0].addr), 32'(a));
        end
        chk("report_addr", 32'(r.addr), 32'(a));
        if (store_mute) begin
          chk("timeout_window", 32'(rel >= 2 + TIMEOUT && rel <= 5 + TIMEOUT), 32'd1);
          chk("timeout_err_set", 32'(timeout_err), 32'd1);
        end else begin
          chk("result_cycle", 32'(rel), pres ? 32'd9 : 32'd7);
          chk("delete_count", 32'(del_log.size()), pres ? 32'd1 : 32'd0);
          if (pres && del_log.size() > 0) chk("delete_cycle", 32'(del_log[0].cyc - t0), 32'd4);
        end
      end
    end
    if (exp_hit) begin
      ref_bricks[a] = 1'b0;
      if (ref_count > 0) ref_count--;
    end
    @(negedge clock);
    #2;
    chk("idle_after", 32'(busy), 32'd0);
    chk("bricks_left", 32'(bricks_left), 32'(ref_count));
    chk("field_clear", 32'(field_clear), 32'(ref_count == 0));
    if (inf) begin
      chk("hit_col", 32'(hit_col), 32'(col));
      chk("hit_row", 32'(hit_row), 32'(row));
    end
  endtask

  task automatic strobe(input int x, input int y);
    @(negedge clock);
    ball_x = 8'(x); ball_y = 7'(y); ball_valid = 1'b1;
    @(negedge clock);
    ball_valid = 1'b0;
  endtask

  initial begin
    bit inf_a, inf_d;
    int a_a, a_d, c_a, r_a, c_d, r_d;

    // reset state
    repeat (3) @(negedge clock);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({hit, miss, check_status, delete_brick}), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_addr", 32'(brick_address), 32'd0);
    chk("rst_hit_pos", 32'({hit_col, hit_row}), 32'd0);
    chk("rst_bricks_left", 32'(bricks_left), 32'(NCELL));
    chk("rst_field_clear", 32'(field_clear), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    do_loading();

    // directed hit, repeat miss, out-of-field
    process(40, 20);
    process(40, 20);
    process(10, 5);
    process(10, 70);

    // random positions over and around the field
    for (int i = 0; i < 24; i++) process($urandom_range(0, 200), $urandom_range(0, 90));

    // store never answers
    store_mute = 1'b1;
    process(56, 20);
    store_mute = 1'b0;
    process(56, 20);
    chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
    do_loading();

    // three strobes during a transaction: only the last one is served
    predict(72, 28, inf_a, a_a, c_a, r_a);
    predict(120, 50, inf_d, a_d, c_d, r_d);
    req_log.delete(); del_log.delete(); res_log.delete();
    strobe(72, 28);       // rel 0
    @(negedge clock);     // rel 2
    strobe(24, 20);       // rel 3
    strobe(136, 60);      // rel 5
    strobe(120, 50);      // rel 7
    wait_res(2, 60);
    repeat (20) @(negedge clock);
    #2;
    chk("pend_req_count", 32'(req_log.size()), 32'd2);
    chk("pend_res_count", 32'(res_log.size()), 32'd2);
    if (req_log.size() >= 2 && res_log.size() >= 2) begin
      chk("pend_first_addr", 32'(req_log[0].addr), 32'(a_a));
      chk("pend_last_addr", 32'(req_log[1].addr), 32'(a_d));
      chk("pend_first_hit", 32'(res_log[0].is_hit), 32'd1);
      chk("pend_last_hit", 32'(res_log[1].is_hit), 32'd1);
    end
    ref_bricks[a_a] = 1'b0;
    ref_bricks[a_d] = 1'b0;
    ref_count -= 2;
    chk("pend_bricks_left", 32'(bricks_left), 32'(ref_count));
    chk("pend_hit_col", 32'(hit_col), 32'(c_d));
    chk("pend_hit_row", 32'(hit_row), 32'(r_d));

    // clear every cell of a fresh field
    do_loading();
    for (int a = 0; a < NCELL; a++)
      process(FIELD_X0 + (a % COLS) * BRICK_W + $urandom_range(0, BRICK_W - 1),
              FIELD_Y0 + (a / COLS) * BRICK_H + $urandom_range(0, BRICK_H - 1));
    chk("cleared_field_clear", 32'(field_clear), 32'd1);

    // a stale brick still reports a hit; the count stays at zero
    store_bricks[5] = 1'b1;
    ref_bricks[5] = 1'b1;
    process(5 * BRICK_W + 3, FIELD_Y0 + 1);
    chk("saturated_left", 32'(bricks_left), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
